// File: rtl/dpram_mover.sv
// Dual-port RAM mover: word copy (port A read -> port B write) or masked fill,
// one word per clock, with range/overlap rejection and abort.
module dpram_mover #(
  parameter int RAM_DEPTH = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [31:0]       fill_data,
  input  logic [3:0]        fill_mask,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_ena,
  output logic [ADDR_W-1:0] ram_addra,
  input  logic [31:0]       ram_douta,
  output logic              ram_enb,
  output logic              ram_web,
  output logic [3:0]        ram_wemb,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic [31:0]       ram_dinb
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  typedef struct packed {
    logic              mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   len;
    logic [31:0]       fdata;
    logic [3:0]        fmask;
  } cfg_t;

  localparam logic [ADDR_W+1:0] DEPTH = (ADDR_W+2)'(RAM_DEPTH);

  state_t            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [ADDR_W:0]   k_q, k_d;
  logic              rej_q, rej_d;

  logic [ADDR_W+1:0] src_end, dst_end;
  logic              reject;
  logic [ADDR_W:0]   last_k;
  logic [ADDR_W-1:0] kk;

  // Range checks run one bit wider than len so src+len never wraps.
  assign src_end = {2'b0, src_addr} + {1'b0, len};
  assign dst_end = {2'b0, dst_addr} + {1'b0, len};
  assign reject  = (!mode && (src_end > DEPTH)) || (dst_end > DEPTH) ||
                   (!mode && (src_addr < dst_addr) && ({2'b0, dst_addr} < src_end));
  assign last_k  = cfg_q.len - 1'b1;
  assign kk      = k_q[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    k_d     = k_q;
    rej_d   = rej_q;
    case (state_q)
      IDLE: if (start) begin
        cfg_d   = '{mode: mode, src: src_addr, dst: dst_addr, len: len,
                    fdata: fill_data, fmask: fill_mask};
        k_d     = '0;
        rej_d   = reject;
        state_d = (reject || len == '0) ? FIN : RUN;
      end
      RUN: begin
        if (abort) state_d = IDLE;
        else if (k_q == last_k) state_d = cfg_q.mode ? FIN : DRAIN;
        else k_d = k_q + 1'b1;
      end
      DRAIN:   state_d = abort ? IDLE : FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      k_q     <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      k_q     <= k_d;
      rej_q   <= rej_d;
    end
  end

  // RAM controls decode from registered state only; copy write data is the
  // previous cycle's read coming straight back from port A.
  always_comb begin
    busy      = (state_q == RUN) || (state_q == DRAIN);
    done      = (state_q == FIN);
    err       = (state_q == FIN) && rej_q;
    ram_ena   = 1'b0;
    ram_addra = '0;
    ram_enb   = 1'b0;
    ram_web   = 1'b0;
    ram_wemb  = 4'h0;
    ram_addrb = '0;
    ram_dinb  = '0;
    if (state_q == RUN && !cfg_q.mode) begin
      ram_ena   = 1'b1;
      ram_addra = cfg_q.src + kk;
      if (k_q != '0) begin
        ram_enb   = 1'b1;
        ram_web   = 1'b1;
        ram_wemb  = 4'hF;
        ram_addrb = cfg_q.dst + kk - ADDR_W'(1);
        ram_dinb  = ram_douta;
      end
    end else if (state_q == RUN) begin
      ram_enb   = 1'b1;
      ram_web   = 1'b1;
      ram_wemb  = cfg_q.fmask;
      ram_addrb = cfg_q.dst + kk;
      ram_dinb  = cfg_q.fdata;
    end else if (state_q == DRAIN) begin
      ram_enb   = 1'b1;
      ram_web   = 1'b1;
      ram_wemb  = 4'hF;
      ram_addrb = cfg_q.dst + cfg_q.len[ADDR_W-1:0] - ADDR_W'(1);
      ram_dinb  = ram_douta;
    end
  end

endmodule

// File: tb/tb_dpram_mover.sv
// Directed bench for dpram_mover with a behavioural dual-port RAM attached.
module tb_dpram_mover;
  localparam int AW = 11;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0, mode = 0, abort = 0;
  logic [AW-1:0] src_addr = 0, dst_addr = 0;
  logic [AW:0]   len = 0;
  logic [31:0]   fill_data = 0;
  logic [3:0]    fill_mask = 0;
  logic          busy, done, err, ram_ena, ram_enb, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [31:0]   ram_douta, ram_dinb;
  logic [3:0]    ram_wemb;

  logic          pl_we = 0;
  logic [AW-1:0] pl_addr = 0;
  logic [31:0]   pl_data = 0;
  logic [31:0]   mem [0:2047];

  int checks = 0, errors = 0;
  int done_cyc, done_cnt, err_seen, enb_cnt, ena_cnt, busy_cnt, first_wr, last_wr;

  always #5 clk = ~clk;

  dpram_mover #(.RAM_DEPTH(2048), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .fill_data(fill_data), .fill_mask(fill_mask), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .ram_ena(ram_ena), .ram_addra(ram_addra), .ram_douta(ram_douta),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_wemb(ram_wemb),
    .ram_addrb(ram_addrb), .ram_dinb(ram_dinb)
  );

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_enb && ram_web)
      for (int b = 0; b < 4; b++)
        if (ram_wemb[b]) mem[ram_addrb][8*b +: 8] <= ram_dinb[8*b +: 8];
    if (ram_ena) ram_douta <= mem[ram_addra];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int base, input int n, input logic [31:0] v0, input logic [31:0] step);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pl_we = 1; pl_addr = AW'(base + i); pl_data = v0 + step * i;
    end
    @(negedge clk); pl_we = 0;
  endtask

  // Start at edge 0; cycle c is the period following edge c-1. Abort/second
  // start are raised in cycle x and sampled at the edge closing it.
  task automatic go(input logic m, input int s, input int d, input int l,
                    input logic [31:0] fd, input logic [3:0] fm,
                    input int abort_cyc, input int poke_cyc, input int rst_cyc);
    done_cyc = 0; done_cnt = 0; err_seen = 0; enb_cnt = 0; ena_cnt = 0;
    busy_cnt = 0; first_wr = 0; last_wr = 0;
    @(negedge clk);
    start = 1; mode = m; src_addr = AW'(s); dst_addr = AW'(d); len = (AW+1)'(l);
    fill_data = fd; fill_mask = fm;
    @(posedge clk); #1; start = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == abort_cyc) abort = 1;
      if (cyc == abort_cyc + 1) abort = 0;
      if (cyc == poke_cyc) begin
        start = 1; mode = ~m; dst_addr = 11'h600; len = 2; fill_data = 32'hFFFF_FFFF;
      end
      if (cyc == poke_cyc + 1) start = 0;
      if (cyc == rst_cyc) begin
        rst_n = 0; #1;
        chk("rst_outs", 32'({busy, done, err, ram_ena, ram_enb, ram_web, |ram_wemb,
                             |ram_addra, |ram_addrb, |ram_dinb}), 0);
        break;
      end
      if (ram_enb) begin
        enb_cnt++; last_wr = cyc;
        if (first_wr == 0) first_wr = cyc;
      end
      if (ram_ena) ena_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin done_cyc = cyc; err_seen = int'(err); end
      end
      @(posedge clk); #1;
    end
    if (rst_cyc > 0) begin @(negedge clk); rst_n = 1; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({busy, done, err, ram_ena, ram_enb, ram_web, ram_wemb}), 0);
    @(negedge clk); rst_n = 1;

    // T1: copy 0x010 -> 0x100, len 4
    preload(32'h010, 4, 32'hA0A0_0000, 1);
    preload(32'h100, 5, 32'h0, 0);
    go(0, 32'h010, 32'h100, 4, 0, 0, -5, -5, -5);
    chk("t1_done_cyc", done_cyc, 6);
    chk("t1_err", err_seen, 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_enb_cnt", enb_cnt, 4);
    chk("t1_ena_cnt", ena_cnt, 4);
    chk("t1_first_wr", first_wr, 2);
    chk("t1_last_wr", last_wr, 5);
    chk("t1_busy_cnt", busy_cnt, 5);
    for (int i = 0; i < 4; i++) chk("t1_mem", mem[32'h100 + i], 32'hA0A0_0000 + i);
    chk("t1_mem_after", mem[32'h104], 0);

    // T2: masked fill at top of memory
    preload(32'h7FC, 4, 32'h1111_1111, 0);
    go(1, 0, 32'h7FC, 4, 32'hDEAD_BEEF, 4'b0101, -5, -5, -5);
    chk("t2_done_cyc", done_cyc, 5);
    chk("t2_err", err_seen, 0);
    chk("t2_enb_cnt", enb_cnt, 4);
    chk("t2_first_wr", first_wr, 1);
    chk("t2_ena_cnt", ena_cnt, 0);
    for (int i = 0; i < 4; i++) chk("t2_mem", mem[32'h7FC + i], 32'h11AD_11EF);

    // T3: rejected requests
    go(0, 32'h7FE, 32'h000, 4, 0, 0, -5, -5, -5);
    chk("t3_range_done", done_cyc, 1);
    chk("t3_range_err", err_seen, 1);
    chk("t3_range_ram", enb_cnt + ena_cnt + busy_cnt, 0);
    go(0, 32'h020, 32'h022, 4, 0, 0, -5, -5, -5);
    chk("t3_ovl_err", err_seen, 1);
    chk("t3_ovl_done", done_cyc, 1);
    go(1, 0, 32'h7FD, 4, 0, 4'hF, -5, -5, -5);
    chk("t3_fill_range_err", err_seen, 1);

    // Backward overlap is legal
    preload(32'h022, 4, 32'hB0B0_0000, 1);
    go(0, 32'h022, 32'h020, 4, 0, 0, -5, -5, -5);
    chk("bk_err", err_seen, 0);
    for (int i = 0; i < 4; i++) chk("bk_mem", mem[32'h020 + i], 32'hB0B0_0000 + i);

    // T4: zero length, then start while busy
    go(0, 32'h010, 32'h200, 0, 0, 0, -5, -5, -5);
    chk("t4_len0_done", done_cyc, 1);
    chk("t4_len0_err", err_seen, 0);
    chk("t4_len0_ram", enb_cnt + ena_cnt, 0);
    preload(32'h600, 2, 32'h0, 0);
    go(0, 32'h010, 32'h140, 4, 0, 0, -5, 2, -5);
    chk("t4_poke_done", done_cyc, 6);
    chk("t4_poke_done_cnt", done_cnt, 1);
    chk("t4_poke_enb", enb_cnt, 4);
    chk("t4_poke_mem", mem[32'h143], 32'hA0A0_0003);
    chk("t4_poke_untouched", mem[32'h600], 0);

    // T5: abort mid-copy, then restart
    preload(32'h300, 16, 32'hC0C0_0000, 1);
    preload(32'h380, 16, 32'h0, 0);
    go(0, 32'h300, 32'h380, 16, 0, 0, 4, -5, -5);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_enb_cnt", enb_cnt, 3);
    chk("t5_busy_cnt", busy_cnt, 4);
    for (int i = 0; i < 3; i++) chk("t5_mem", mem[32'h380 + i], 32'hC0C0_0000 + i);
    chk("t5_mem_unwritten", mem[32'h383], 0);
    go(1, 0, 32'h390, 2, 32'h5A5A_5A5A, 4'hF, -5, -5, -5);
    chk("t5_restart_done", done_cyc, 3);
    chk("t5_restart_mem", mem[32'h391], 32'h5A5A_5A5A);

    // T6: reset mid-fill
    preload(32'h500, 8, 32'h0, 0);
    go(1, 0, 32'h500, 8, 32'h1234_5678, 4'hF, -5, -5, 3);
    chk("t6_mem_written", mem[32'h501], 32'h1234_5678);
    chk("t6_mem_cut", mem[32'h502], 0);
    go(1, 0, 32'h506, 1, 32'h8765_4321, 4'hF, -5, -5, -5);
    chk("t6_restart_done", done_cyc, 2);
    chk("t6_restart_mem", mem[32'h506], 32'h8765_4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
